muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide engine producing HI/LO results for the execute stage; it replaces the fixed 32-bit divider and its decode glue.
- Handles signed and unsigned multiply and divide on the same start/ready handshake.
- Provides a cancel input so an exception flush can kill an in-flight operation.
- Drives a busy flag that the hazard unit uses to stall the pipeline.

Parameters:
- WIDTH, 32: operand width; hi_o/lo_o are each WIDTH bits.
- MUL_STAGES, 2: multiply latency in cycles (>=1), as a pipelined register chain.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start_i  in  1  request; sampled only when the unit is idle.
- op_i  in  1  0 = multiply, 1 = divide.
- signed_i  in  1  1 = two's-complement operands.
- a_i  in  WIDTH  multiplicand / dividend.
- b_i  in  WIDTH  multiplier / divisor.
- cancel_i  in  1  abort the current operation (exception flush).
- busy_o  out  1  operation in flight; the pipeline stalls on it.
- ready_o  out  1  one-cycle pulse: hi_o/lo_o updated this cycle.
- hi_o  out  WIDTH  product upper half / remainder.
- lo_o  out  WIDTH  product lower half / quotient.

Behaviour:
- Reset (rst==0 at an edge): state IDLE; busy_o=0, ready_o=0, hi_o=0, lo_o=0; any in-flight operation is discarded. This applies mid-operation as well.
- States: IDLE, MUL, DIV, DONE.
- IDLE + start_i & ~cancel_i:
  - latch a_i, b_i, op_i, signed_i;
  - enter MUL or DIV;
  - busy_o=1 from the next cycle.
- Start edge is cycle 0. ready_o is high in cycle L and the state is DONE in that cycle.
  - Multiply: L = MUL_STAGES.
  - Divide: L = WIDTH+1 (one setup cycle taking absolute values, then WIDTH restoring iterations).
- DONE: ready_o=1 and busy_o=0 for that cycle, with hi_o/lo_o updated. Next state is IDLE.
  - start_i sampled in DONE is ignored; a back-to-back issue starts the cycle after DONE.
- busy_o is 1 exactly in cycles 1..L-1 of an operation.
- hi_o/lo_o hold their last value until the next ready_o. They never change on cancel or on an ignored start.
- start_i while busy: ignored; operands are not re-latched.
- cancel_i in MUL/DIV/DONE: next state IDLE.
  - If cancel_i is asserted in the cycle that would become DONE, ready_o is suppressed.
  - Outputs are not updated; busy_o=0 the next cycle.
- cancel_i together with start_i in IDLE: cancel wins; nothing starts.
- Multiply:
  - full 2*WIDTH product, {hi_o, lo_o};
  - signed uses two's-complement sign extension;
  - unsigned is zero-extended.
- Divide:
  - lo_o = quotient, hi_o = remainder;
  - signed: quotient sign = sign(a) xor sign(b); remainder sign = sign(a); truncation toward zero.
- Signed overflow (a = most negative, b = -1): lo_o = most negative, hi_o = 0. No trap.
- Divide by zero (either signedness):
  - lo_o = all ones, hi_o = a (the latched value);
  - full latency L is still taken; no error flag.
- Operands are captured at start. Later changes on a_i/b_i do not affect the result.
- The iteration counter is ceil(log2(WIDTH+1)) bits. It is cleared on start and compared to WIDTH for the DIV exit.

Test Plan (WIDTH=32, MUL_STAGES=2):
- Signed multiply: start op=0, signed=1, a=0xFFFFFFFD (-3), b=5.
  - ready_o at cycle 2; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
  - busy_o high in cycle 1 only.
- Unsigned multiply: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - hi_o=0xFFFFFFFE, lo_o=0x00000001 at cycle 2.
- Divide:
  - unsigned a=100, b=7: ready_o at cycle 33; lo_o=14, hi_o=2.
  - signed a=-7, b=2: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
  - signed a=0x80000000, b=0xFFFFFFFF: lo_o=0x80000000, hi_o=0.
- Divide by zero: unsigned a=0x1234, b=0.
  - ready_o at cycle 33; lo_o=0xFFFFFFFF, hi_o=0x1234.
- Cancel:
  - Divide started, cancel_i pulsed at cycle 10: no ready_o ever; busy_o=0 from cycle 11; hi_o/lo_o keep the prior values.
  - Immediate restart: a new multiply started at cycle 12 completes at cycle 14.
  - start_i and cancel_i together in IDLE: busy_o stays 0.
- Reset and ignored start:
  - rst=0 at cycle 20 of a divide: next cycle busy_o=0, ready_o=0, hi_o=lo_o=0; no later ready_o.
  - start_i pulsed during a busy divide: ignored; the result matches the original operands.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply/divide engine with HI/LO results
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int MW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q, b_q, dvsr, quo, rem;
    logic               signed_q;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [MW-1:0]      mul_cnt;
    logic [2*WIDTH-1:0] ext_a, ext_b, mul_in, mul_res;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix, a_abs, b_abs;
    logic               accept;

    assign accept  = start_i & ~cancel_i;
    assign busy_o  = (state == S_MUL) || (state == S_DIV);
    assign ready_o = (state == S_DONE);

    always_comb begin
        ext_a   = signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        ext_b   = signed_i ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        mul_in  = ext_a * ext_b;
        a_abs   = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs   = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        cnt_nxt = cnt + 1'b1;
        // Restoring step: the dividend shifts out of quo into rem as quotient bits shift in.
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
        quo_fix = (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_nxt : quo_nxt;
        rem_fix = (signed_q && a_q[WIDTH-1]) ? -rem_nxt : rem_nxt;
    end

    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_res = mul_in;
        end else begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < MUL_STAGES - 1; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= mul_in;
                    for (int k = 1; k < MUL_STAGES - 1; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign mul_res = pipe[MUL_STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            dvsr     <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            mul_cnt  <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        signed_q <= signed_i;
                        quo      <= a_abs;
                        dvsr     <= b_abs;
                        rem      <= '0;
                        cnt      <= '0;
                        mul_cnt  <= '0;
                        if (op_i) begin
                            state <= S_DIV;
                        end else if (MUL_STAGES == 1) begin
                            state <= S_DONE;
                            hi_o  <= mul_res[2*WIDTH-1:WIDTH];
                            lo_o  <= mul_res[WIDTH-1:0];
                        end else begin
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cancel_i) begin
                        state <= S_IDLE;
                    end else if (mul_cnt == MW'(MUL_STAGES - 2)) begin
                        state <= S_DONE;
                        hi_o  <= mul_res[2*WIDTH-1:WIDTH];
                        lo_o  <= mul_res[WIDTH-1:0];
                    end else begin
                        mul_cnt <= mul_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cancel_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == CW'(WIDTH)) begin
                            state <= S_DONE;
                            hi_o  <= (b_q == '0) ? a_q : rem_fix;
                            lo_o  <= (b_q == '0) ? '1  : quo_fix;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0, op_i = 1'b0, signed_i = 1'b0, cancel_i = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        busy_o, ready_o;
    logic [31:0] hi_o, lo_o;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] cur = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .busy_o(busy_o), .ready_o(ready_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic op, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        if (!op) begin
            if (sgn) begin
                p = longint'(sa) * longint'(sb);
                return 64'(p);
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (sa == 32'sh8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Issues in the current cycle (cycle 0); optionally pokes start_i while busy and in DONE.
    task automatic run_op(input logic op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int ign_at, input logic done_start);
        logic [63:0] e;
        int lat;
        e = model(op, sgn, a, b);
        lat = op ? 33 : 2;
        start_i = 1'b1; op_i = op; signed_i = sgn; a_i = a; b_i = b;
        tick;
        start_i = 1'b0; a_i = $urandom; b_i = $urandom;
        for (int c = 1; c < lat; c++) begin
            check($sformatf("busy c%0d", c), {63'b0, busy_o}, 64'd1);
            check($sformatf("early_ready c%0d", c), {63'b0, ready_o}, 64'd0);
            if (c == ign_at) begin
                start_i = 1'b1; op_i = $urandom; signed_i = $urandom;
            end
            tick;
            start_i = 1'b0;
        end
        check("ready_at_L", {62'b0, ready_o, busy_o}, 64'b10);
        check($sformatf("result op%0d s%0d %h/%h", op, sgn, a, b), {hi_o, lo_o}, e);
        cur = e;
        start_i = done_start; op_i = 1'b0;
        tick;
        start_i = 1'b0;
        check("after_done", {62'b0, ready_o, busy_o}, 64'b0);
        check("hold_after_done", {hi_o, lo_o}, cur);
    endtask

    task automatic watch_idle(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            check(tag, {62'b0, ready_o, busy_o, hi_o, lo_o}, {62'b0, 2'b00, cur});
            tick;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rop, rsg;

        rst = 1'b0;
        tick; tick;
        check("reset_flags", {62'b0, ready_o, busy_o}, 64'b0);
        check("reset_hilo", {hi_o, lo_o}, 64'h0);
        rst = 1'b1;
        tick;

        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(1'b1, 1'b0, 32'h0000_1234, 32'd0, 0, 1'b0);
        run_op(1'b1, 1'b1, 32'hFFFF_0000, 32'd0, 0, 1'b0);
        run_op(1'b1, 1'b0, 32'd1000, 32'd13, 5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = $urandom; rsg = $urandom; ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) rb = $urandom_range(1, 9);
            run_op(rop, rsg, ra, rb, (i % 3 == 0) ? 4 : 0, i[0]);
        end

        // Cancel a divide in cycle 10, then restart a multiply in cycle 12.
        start_i = 1'b1; op_i = 1'b1; signed_i = 1'b0; a_i = 32'd555; b_i = 32'd3;
        tick;
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        cancel_i = 1'b1;
        tick;
        cancel_i = 1'b0;
        check("cancel_idle_c11", {62'b0, ready_o, busy_o}, 64'b0);
        check("cancel_hold_c11", {hi_o, lo_o}, cur);
        tick;
        run_op(1'b0, 1'b0, 32'd12345, 32'd678, 0, 1'b0);

        start_i = 1'b1; op_i = 1'b1; signed_i = 1'b1; a_i = 32'd77; b_i = 32'd5;
        tick;
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) tick;
        cancel_i = 1'b1;
        tick;
        cancel_i = 1'b0;
        watch_idle(40, "cancel_no_ready");

        // Cancel in the cycle that would become DONE.
        start_i = 1'b1; op_i = 1'b0; signed_i = 1'b0; a_i = 32'd9; b_i = 32'd9;
        tick;
        start_i = 1'b0;
        cancel_i = 1'b1;
        tick;
        cancel_i = 1'b0;
        watch_idle(5, "cancel_last_cycle");

        start_i = 1'b1; cancel_i = 1'b1; op_i = 1'b1; a_i = 32'd4; b_i = 32'd2;
        tick;
        start_i = 1'b0; cancel_i = 1'b0;
        watch_idle(40, "start_cancel_idle");

        // Reset in cycle 20 of a divide.
        start_i = 1'b1; op_i = 1'b1; signed_i = 1'b0; a_i = 32'd999; b_i = 32'd10;
        tick;
        start_i = 1'b0;
        for (int c = 1; c < 20; c++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        cur = 64'h0;
        watch_idle(40, "reset_mid_div");

        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
